// File: rtl/axis_vec_ser_pkg.sv
// Shared types and helpers for the wide-to-narrow result vector serializer.
package axis_vec_ser_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int unsigned SEXT_MAX_W = 64;

   // Sign-extends the low w bits of val across the full SEXT_MAX_W width.
   function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] val,
                                                  input int unsigned            w);
      logic [SEXT_MAX_W-1:0] mask;
      logic                  sign;
      mask = ~((SEXT_MAX_W'(1) << w) - SEXT_MAX_W'(1));
      sign = |((val >> (w - 1)) & SEXT_MAX_W'(1));
      return sign ? (val | mask) : (val & ~mask);
   endfunction

endpackage

// File: rtl/axis_vec_serializer.sv
// Takes one R-word signed result vector per wide beat and emits it as R
// sign-extended narrow AXI-Stream beats, word 0 first, TLAST on the final word.
module axis_vec_serializer
   import axis_vec_ser_pkg::*;
#(
   parameter int unsigned R     = 8,
   parameter int unsigned W_Y   = 19,
   parameter int unsigned BUS_W = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_axis_y_tvalid,
   output logic               s_axis_y_tready,
   input  logic [R*W_Y-1:0]   s_axis_y_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [BUS_W-1:0]   m_axis_tdata,
   output logic               m_axis_tlast
);
   //  state | meaning
   //  IDLE  | buffer empty, wide input accepted
   //  SEND  | buffer holds a vector, narrow beat r_idx presented on m_axis

   localparam int unsigned IDX_W = (R > 1) ? $clog2(R) : 1;

   if (BUS_W < W_Y || BUS_W > SEXT_MAX_W) begin : g_bad_width
      $error("axis_vec_serializer: BUS_W must satisfy W_Y <= BUS_W <= %0d", SEXT_MAX_W);
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_en;
   logic [IDX_W-1:0]   r_idx;
   logic [W_Y-1:0]     r_buf [R];
   logic               r_tvalid;
   logic [BUS_W-1:0]   r_tdata;
   logic               r_tlast;

   logic               w_s_tready;
   logic               w_s_hs;
   logic               w_m_hs;
   logic               w_last;
   logic [IDX_W-1:0]   w_idx_nxt;

   assign w_last    = (r_idx == IDX_W'(R - 1));
   assign w_idx_nxt = r_idx + 1'b1;
   assign w_s_hs    = s_axis_y_tvalid & w_s_tready;
   assign w_m_hs    = r_tvalid & m_axis_tready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_s_hs) w_state_nxt = SEND;
         SEND:    if (w_m_hs && w_last && !w_s_hs) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // On the last beat, input readiness follows the sink so packets chain without a bubble.
   always_comb begin
      w_s_tready = 1'b0;
      case (r_state)
         IDLE:    w_s_tready = r_en;
         SEND:    w_s_tready = r_en & w_last & m_axis_tready;
         default: w_s_tready = 1'b0;
      endcase
   end

   // Delays input readiness by one edge after reset release.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_en <= 1'b0;
      end else begin
         r_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_idx    <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
         for (int k = 0; k < int'(R); k++) begin
            r_buf[k] <= '0;
         end
      end else if (w_s_hs) begin
         for (int k = 0; k < int'(R); k++) begin
            r_buf[k] <= s_axis_y_tdata[k*W_Y +: W_Y];
         end
         r_idx    <= '0;
         r_tvalid <= 1'b1;
         r_tdata  <= BUS_W'(sext(SEXT_MAX_W'(s_axis_y_tdata[0 +: W_Y]), W_Y));
         r_tlast  <= (R == 1);
      end else if (w_m_hs) begin
         if (!w_last) begin
            r_idx   <= w_idx_nxt;
            r_tdata <= BUS_W'(sext(SEXT_MAX_W'(r_buf[w_idx_nxt]), W_Y));
            r_tlast <= (w_idx_nxt == IDX_W'(R - 1));
         end else begin
            r_idx    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end
      end
   end

   assign s_axis_y_tready = w_s_tready;
   assign m_axis_tvalid   = r_tvalid;
   assign m_axis_tdata    = r_tdata;
   assign m_axis_tlast    = r_tlast;

endmodule

// File: tb/tb_axis_vec_serializer.sv
// Directed and randomized checks of axis_vec_serializer (R=8, W_Y=19, BUS_W=32).
module tb_axis_vec_serializer;
   localparam int R     = 8;
   localparam int W_Y   = 19;
   localparam int BUS_W = 32;
   localparam int N_RND = 500;

   logic               clk;
   logic               rstn;
   logic               s_tvalid;
   logic               s_tready;
   logic [R*W_Y-1:0]   s_tdata;
   logic               m_tvalid;
   logic               m_tready;
   logic [BUS_W-1:0]   m_tdata;
   logic               m_tlast;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] got_data [$];
   logic        got_last [$];
   logic        got_str  [$];
   int          got_cyc  [$];
   logic [31:0] exp_data [$];
   logic        exp_last [$];
   logic        sb_en = 1'b0;

   axis_vec_serializer #(.R(R), .W_Y(W_Y), .BUS_W(BUS_W)) u_dut (
      .clk             (clk),
      .rstn            (rstn),
      .s_axis_y_tvalid (s_tvalid),
      .s_axis_y_tready (s_tready),
      .s_axis_y_tdata  (s_tdata),
      .m_axis_tvalid   (m_tvalid),
      .m_axis_tready   (m_tready),
      .m_axis_tdata    (m_tdata),
      .m_axis_tlast    (m_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sx(input logic [18:0] v);
      return {{13{v[18]}}, v};
   endfunction

   // Beat capture plus AXIS hold-stable rule while stalled.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;
   logic        prev_last  = 1'b0;
   always @(negedge clk) begin
      if (rstn) begin
         if (prev_stall) begin
            chk("hold_valid", m_tvalid, 1'b1);
            chk("hold_data", m_tdata, prev_data);
            chk("hold_last", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) begin
            got_data.push_back(m_tdata);
            got_last.push_back(m_tlast);
            got_str.push_back(s_tready);
            got_cyc.push_back(cyc);
         end
         prev_stall = m_tvalid & ~m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      got_data.delete();
      got_last.delete();
      got_str.delete();
      got_cyc.delete();
   endtask

   task automatic send_vec(input logic [R*W_Y-1:0] v, output int hs_cyc);
      logic hs;
      hs       = 1'b0;
      hs_cyc   = -1;
      s_tvalid = 1'b1;
      s_tdata  = v;
      for (int n = 0; n < 2000 && !hs; n++) begin
         @(negedge clk);
         if (s_tready) begin
            hs     = 1'b1;
            hs_cyc = cyc;
            if (sb_en) begin
               for (int r = 0; r < R; r++) begin
                  exp_data.push_back(sx(v[r*W_Y +: W_Y]));
                  exp_last.push_back(r == R - 1);
               end
            end
         end
         step();
      end
      s_tvalid = 1'b0;
      if (!hs) chk("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_beats(input int n, input string tag);
      for (int i = 0; i < 500 && got_data.size() < n; i++) step();
      chk(tag, got_data.size(), n);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [R*W_Y-1:0] v;
      logic [R*W_Y-1:0] va;
      logic [18:0]      y [R];
      int               hs;
      int               hs2;
      logic             src_done;
      int               nlast;

      rstn     = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b0;
      #1;
      chk("rst_tvalid", m_tvalid, 1'b0);
      chk("rst_tlast", m_tlast, 1'b0);
      chk("rst_tdata", m_tdata, 32'h0);
      chk("rst_s_tready", s_tready, 1'b0);
      step();
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk("rel_s_tready0", s_tready, 1'b0);
      step();
      @(negedge clk);
      chk("rel_s_tready1", s_tready, 1'b1);
      step();

      // 1: y[r]=r+1, sink always ready
      m_tready = 1'b1;
      for (int r = 0; r < R; r++) v[r*W_Y +: W_Y] = 19'(r + 1);
      send_vec(v, hs);
      wait_beats(8, "t1_count");
      if (got_data.size() == 8) begin
         chk("t1_latency", got_cyc[0], hs + 1);
         for (int k = 0; k < 8; k++) begin
            chk("t1_data", got_data[k], k + 1);
            chk("t1_last", got_last[k], k == 7);
            chk("t1_consec", got_cyc[k], got_cyc[0] + k);
         end
      end
      step();
      @(negedge clk);
      chk("t1_idle_tvalid", m_tvalid, 1'b0);
      chk("t1_idle_s_tready", s_tready, 1'b1);
      step();
      clear_q();

      // 2: sign extension at the extremes
      y[0] = 19'h7FFFB; y[1] = 19'h40000; y[2] = 19'h00000; y[3] = 19'h7FFFF;
      y[4] = 19'h12345; y[5] = 19'h6789A; y[6] = 19'h00001; y[7] = 19'h3FFFF;
      for (int r = 0; r < R; r++) v[r*W_Y +: W_Y] = y[r];
      send_vec(v, hs);
      wait_beats(8, "t2_count");
      if (got_data.size() == 8) begin
         chk("t2_beat0", got_data[0], 32'hFFFFFFFB);
         chk("t2_beat1", got_data[1], 32'hFFFC0000);
         chk("t2_beat3", got_data[3], 32'hFFFFFFFF);
         chk("t2_beat5", got_data[5], 32'hFFFE789A);
         chk("t2_beat7", got_data[7], 32'h0003FFFF);
         chk("t2_beat4", got_data[4], 32'h00012345);
      end
      step();
      clear_q();

      // 3: two vectors back-to-back, no bubble
      for (int r = 0; r < R; r++) va[r*W_Y +: W_Y] = 19'(16'h100 + r);
      for (int r = 0; r < R; r++) v[r*W_Y +: W_Y]  = 19'(19'h7FF00 + r);
      send_vec(va, hs);
      send_vec(v, hs2);
      wait_beats(16, "t3_count");
      if (got_data.size() == 16) begin
         chk("t3_b2b_hs", hs2, hs + 8);
         for (int k = 0; k < 16; k++) begin
            chk("t3_data", got_data[k], (k < 8) ? sx(va[k*W_Y +: W_Y]) : sx(v[(k-8)*W_Y +: W_Y]));
            chk("t3_last", got_last[k], (k == 7) || (k == 15));
            chk("t3_s_tready", got_str[k], (k == 7) || (k == 15));
            chk("t3_consec", got_cyc[k], got_cyc[0] + k);
         end
      end
      step();
      clear_q();

      // 4: sink stalls 3 cycles on beat 4
      for (int r = 0; r < R; r++) v[r*W_Y +: W_Y] = 19'(19'h7FFF0 + r * 3);
      send_vec(v, hs);
      for (int i = 0; i < 4; i++) step();
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_tvalid", m_tvalid, 1'b1);
         chk("t4_tdata", m_tdata, sx(v[4*W_Y +: W_Y]));
         chk("t4_tlast", m_tlast, 1'b0);
         chk("t4_s_tready", s_tready, 1'b0);
         step();
      end
      m_tready = 1'b1;
      wait_beats(8, "t4_count");
      if (got_data.size() == 8) begin
         for (int k = 0; k < 8; k++) chk("t4_data", got_data[k], sx(v[k*W_Y +: W_Y]));
      end
      step();
      clear_q();

      // 5: reset during beat 5
      for (int r = 0; r < R; r++) v[r*W_Y +: W_Y] = 19'(19'h00A00 + r);
      send_vec(v, hs);
      for (int i = 0; i < 5; i++) step();
      @(negedge clk);
      chk("t5_pre_tdata", m_tdata, sx(v[5*W_Y +: W_Y]));
      #1;
      rstn = 1'b0;
      #1;
      chk("t5_rst_tvalid", m_tvalid, 1'b0);
      chk("t5_rst_tdata", m_tdata, 32'h0);
      chk("t5_rst_s_tready", s_tready, 1'b0);
      step();
      step();
      rstn = 1'b1;
      clear_q();
      @(negedge clk);
      chk("t5_rel_s_tready0", s_tready, 1'b0);
      step();
      @(negedge clk);
      chk("t5_rel_s_tready1", s_tready, 1'b1);
      chk("t5_no_remainder", m_tvalid, 1'b0);
      step();
      chk("t5_no_beats", got_data.size(), 0);
      for (int r = 0; r < R; r++) va[r*W_Y +: W_Y] = 19'(19'h55000 + r);
      send_vec(va, hs);
      wait_beats(8, "t5_count");
      if (got_data.size() == 8) begin
         chk("t5_first", got_data[0], sx(va[0 +: W_Y]));
         chk("t5_last", got_data[7], sx(va[7*W_Y +: W_Y]));
      end
      step();
      clear_q();

      // 6: random traffic against scoreboard
      sb_en    = 1'b1;
      src_done = 1'b0;
      fork
         begin
            for (int n = 0; n < N_RND; n++) begin
               while ($urandom_range(0, 99) < 50) step();
               for (int r = 0; r < R; r++) v[r*W_Y +: W_Y] = 19'($urandom);
               send_vec(v, hs);
            end
            src_done = 1'b1;
         end
         begin
            for (int b = 0; b < 60000 && !(src_done && got_data.size() >= N_RND * R); b++) begin
               m_tready = ($urandom_range(0, 99) < 50);
               step();
            end
            m_tready = 1'b1;
         end
      join
      step();
      chk("t6_count", got_data.size(), exp_data.size());
      nlast = 0;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
         chk("t6_data", got_data[k], exp_data[k]);
         chk("t6_last", got_last[k], exp_last[k]);
      end
      for (int k = 0; k < got_last.size(); k++) if (got_last[k]) nlast++;
      chk("t6_tlast_count", nlast, N_RND);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
